// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer for the multi-cycle RV32I core.
// Build option: define MULTICYCLE_CTL_TRAP_EN to add a TRAP state and illegal_inst output.

package multicycle_control_pkg;
  typedef enum logic [1:0] {ALUOP_ADD = 2'd0, ALUOP_SUB = 2'd1, ALUOP_FUNCT = 2'd2} aluop_t;
  typedef enum logic [1:0] {PCSEL_PCPLUS4 = 2'd0, PCSEL_PCPLUSIMM = 2'd1, PCSEL_RPLUSIMM = 2'd2} pcsel_t;
endpackage

module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned INSTRET_W   = 32,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           inst_opc,
  input  logic                 take_branch,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 CTL_IorD,
  output logic                 CTL_IRWrite,
  output logic                 CTL_PcWrite,
  output logic [1:0]           CTL_PcSel,
  output logic                 CTL_RegWrite,
  output aluop_t               CTL_AluOp,
  output logic                 CTL_AluSrc,
  output logic                 CTL_MemRead,
  output logic                 CTL_MemWrite,
  output logic [2:0]           CTL_MemToReg,
  output logic                 bus_err,
  output logic [INSTRET_W-1:0] instret
`ifdef MULTICYCLE_CTL_TRAP_EN
  ,
  output logic                 illegal_inst
`endif
);

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam int unsigned CNT_W   = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int unsigned TO_LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
`ifdef MULTICYCLE_CTL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  state_t             state, stateNext;
  logic [CNT_W-1:0]   waitCnt;
  logic               waiting, timeout, retire;

  assign waiting = (state == S_FETCH) || (state == S_MEM);
  assign timeout = (MEM_TIMEOUT != 0) && waiting && !mem_ready && (waitCnt == CNT_W'(TO_LAST));

`ifdef MULTICYCLE_CTL_TRAP_EN
  assign illegal_inst = (state == S_TRAP);
`endif

  // Outputs are forced to their idle values while rst is high so an in-flight request is dropped.
  always_comb begin
    stateNext    = state;
    retire       = 1'b0;
    mem_req      = 1'b0;
    CTL_IorD     = 1'b0;
    CTL_IRWrite  = 1'b0;
    CTL_PcWrite  = 1'b0;
    CTL_PcSel    = PCSEL_PCPLUS4;
    CTL_RegWrite = 1'b0;
    CTL_AluOp    = ALUOP_ADD;
    CTL_AluSrc   = 1'b0;
    CTL_MemRead  = 1'b0;
    CTL_MemWrite = 1'b0;
    CTL_MemToReg = 3'd0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          mem_req     = 1'b1;
          CTL_MemRead = 1'b1;
          if (mem_ready) begin
            CTL_IRWrite = 1'b1;
            CTL_PcWrite = 1'b1;
            stateNext   = S_DECODE;
          end
        end
        S_DECODE: stateNext = S_EXEC;
        S_EXEC: begin
          case (inst_opc)
            OPC_R: begin
              CTL_AluOp = ALUOP_FUNCT;
              stateNext = S_WB;
            end
            OPC_IALU: begin
              CTL_AluSrc = 1'b1;
              CTL_AluOp  = ALUOP_FUNCT;
              stateNext  = S_WB;
            end
            OPC_LOAD, OPC_STORE: begin
              CTL_AluSrc = 1'b1;
              stateNext  = S_MEM;
            end
            OPC_BRANCH: begin
              CTL_AluOp   = ALUOP_SUB;
              CTL_PcWrite = take_branch;
              CTL_PcSel   = PCSEL_PCPLUSIMM;
              stateNext   = S_FETCH;
              retire      = 1'b1;
            end
            OPC_JAL: begin
              CTL_PcWrite = 1'b1;
              CTL_PcSel   = PCSEL_PCPLUSIMM;
              stateNext   = S_WB;
            end
            OPC_JALR: begin
              CTL_AluSrc  = 1'b1;
              CTL_PcWrite = 1'b1;
              CTL_PcSel   = PCSEL_RPLUSIMM;
              stateNext   = S_WB;
            end
            OPC_LUI, OPC_AUIPC: stateNext = S_WB;
            default: begin
`ifdef MULTICYCLE_CTL_TRAP_EN
              stateNext = S_TRAP;
`else
              stateNext = S_FETCH;
              retire    = 1'b1;
`endif
            end
          endcase
        end
        S_MEM: begin
          mem_req      = 1'b1;
          CTL_IorD     = 1'b1;
          CTL_MemRead  = (inst_opc == OPC_LOAD);
          CTL_MemWrite = (inst_opc == OPC_STORE);
          if (mem_ready) begin
            if (inst_opc == OPC_LOAD) begin
              stateNext = S_WB;
            end else begin
              stateNext = S_FETCH;
              retire    = 1'b1;
            end
          end else if (timeout) begin
            stateNext = S_FETCH;
          end
        end
        S_WB: begin
          CTL_RegWrite = 1'b1;
          case (inst_opc)
            OPC_LOAD:          CTL_MemToReg = 3'd1;
            OPC_JAL, OPC_JALR: CTL_MemToReg = 3'd2;
            OPC_LUI:           CTL_MemToReg = 3'd3;
            default:           CTL_MemToReg = 3'd0;
          endcase
          stateNext = S_FETCH;
          retire    = 1'b1;
        end
`ifdef MULTICYCLE_CTL_TRAP_EN
        S_TRAP: stateNext = S_TRAP;
`endif
        default: stateNext = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      waitCnt <= '0;
      bus_err <= 1'b0;
      instret <= '0;
    end else begin
      state <= stateNext;
      // A fetch timeout stays in FETCH, so the counter must be cleared explicitly there.
      waitCnt <= (!waiting || timeout || (stateNext != state)) ? '0 : waitCnt + CNT_W'(1);
      if (timeout) bus_err <= 1'b1;
      if (retire)  instret <= instret + INSTRET_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle expected outputs are built from
// per-instruction scripts (fetch/decode/exec/mem/wb rules) under random opcodes and memory latency.
module tb_multicycle_control;

  localparam int unsigned TO = 4;
  localparam int unsigned IW = 4;

  localparam logic [6:0] OP_R   = 7'b0110011, OP_I    = 7'b0010011, OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011, OP_BR   = 7'b1100011, OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_BAD = 7'h7F;
  localparam logic [1:0] A_ADD = 2'd0, A_SUB = 2'd1, A_FUNCT = 2'd2;

`ifdef MULTICYCLE_CTL_TRAP_EN
  localparam int unsigned NPOOL = 9;
  localparam int unsigned NB = 4;
`else
  localparam int unsigned NPOOL = 10;
  localparam int unsigned NB = 5;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1, take_branch = 1'b0, mem_ready = 1'b0;
  logic [6:0] inst_opc = '0;
  logic mem_req, CTL_IorD, CTL_IRWrite, CTL_PcWrite, CTL_RegWrite, CTL_AluSrc;
  logic CTL_MemRead, CTL_MemWrite, bus_err;
  logic [1:0] CTL_PcSel, CTL_AluOp;
  logic [2:0] CTL_MemToReg;
  logic [IW-1:0] instret;
`ifdef MULTICYCLE_CTL_TRAP_EN
  logic illegal_inst;
`endif

  always #5 clk = ~clk;

  multicycle_control #(.INSTRET_W(IW), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .inst_opc(inst_opc), .take_branch(take_branch), .mem_ready(mem_ready),
    .mem_req(mem_req), .CTL_IorD(CTL_IorD), .CTL_IRWrite(CTL_IRWrite), .CTL_PcWrite(CTL_PcWrite),
    .CTL_PcSel(CTL_PcSel), .CTL_RegWrite(CTL_RegWrite), .CTL_AluOp(CTL_AluOp),
    .CTL_AluSrc(CTL_AluSrc), .CTL_MemRead(CTL_MemRead), .CTL_MemWrite(CTL_MemWrite),
    .CTL_MemToReg(CTL_MemToReg), .bus_err(bus_err), .instret(instret)
`ifdef MULTICYCLE_CTL_TRAP_EN
    , .illegal_inst(illegal_inst)
`endif
  );

  typedef struct packed {
    logic memReq, iord, irw, pcw;
    logic [1:0] pcsel;
    logic regw;
    logic [1:0] aluop;
    logic alusrc, mrd, mwr;
    logic [2:0] m2r;
    logic busErr;
    logic [IW-1:0] instret;
  } exp_t;

  exp_t cur, act;
  string curTag = "";
  bit curValid = 1'b0;
  int checks = 0, errors = 0;
  int unsigned mInstret = 0;
  bit mBusErr = 1'b0;
  bit pendValid = 1'b0;
  string pendTag;
  int unsigned pendInst, pendBe;

  function automatic string fmt(exp_t e);
    return $sformatf("req%b iord%b irw%b pcw%b pcsel%0d regw%b alu%0d src%b rd%b wr%b m2r%0d berr%b inst%0d",
      e.memReq, e.iord, e.irw, e.pcw, e.pcsel, e.regw, e.aluop, e.alusrc, e.mrd, e.mwr, e.m2r,
      e.busErr, e.instret);
  endfunction

  always @(negedge clk) begin
    if (curValid) begin
      act = {mem_req, CTL_IorD, CTL_IRWrite, CTL_PcWrite, CTL_PcSel, CTL_RegWrite, CTL_AluOp,
             CTL_AluSrc, CTL_MemRead, CTL_MemWrite, CTL_MemToReg, bus_err, instret};
      checks++;
      if (act !== cur) begin
        errors++;
        $display("FAIL %s t=%0t got {%s} expected {%s}", curTag, $time, fmt(act), fmt(cur));
      end
    end
  end

  function automatic void lit(string tag, int unsigned a, int unsigned b);
    checks++;
    if (a != b) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, a, b);
    end
  endfunction

  function automatic exp_t base();
    exp_t e;
    e = '0;
    e.busErr  = mBusErr;
    e.instret = IW'(mInstret);
    return e;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic expectNext(input string tag, input int unsigned inst, input int unsigned be);
    pendValid = 1'b1; pendTag = tag; pendInst = inst; pendBe = be;
  endtask

  task automatic step(input logic r, input logic mr, input logic tbr, input logic [6:0] op,
                      input exp_t e, input string tag);
    @(posedge clk);
    #1;
    rst = r; mem_ready = mr; take_branch = tbr; inst_opc = op;
    cur = e; curTag = tag; curValid = 1'b1;
    if (pendValid) begin
      #1;
      lit({pendTag, "-instret"}, instret, pendInst);
      lit({pendTag, "-bus_err"}, bus_err, pendBe);
      pendValid = 1'b0;
    end
  endtask

  function automatic int unsigned pickDelay();
    return ($urandom_range(0, 7) == 0) ? TO + $urandom_range(0, 2) : $urandom_range(0, TO - 1);
  endfunction

  // fd < 0 picks a random latency; a latency of TO or more ends in a timeout and a re-fetch.
  task automatic doFetch(input int fd);
    exp_t e;
    int unsigned d;
    for (int unsigned tries = 0; tries < 8; tries++) begin
      d = (tries == 0 && fd >= 0) ? fd : (tries >= 2 ? 0 : pickDelay());
      for (int unsigned i = 0; i <= d && i < TO; i++) begin
        e = base(); e.memReq = 1'b1; e.mrd = 1'b1;
        if (i == d) begin
          e.irw = 1'b1; e.pcw = 1'b1;
          step(1'b0, 1'b1, rb(), 7'($urandom), e, "fetch-accept");
          return;
        end
        step(1'b0, 1'b0, rb(), 7'($urandom), e, (i == TO - 1) ? "fetch-timeout" : "fetch-wait");
      end
      mBusErr = 1'b1;
    end
  endtask

  task automatic doMem(input logic [6:0] op, input int md, output bit ok);
    exp_t e;
    int unsigned d;
    d = (md >= 0) ? md : pickDelay();
    ok = 1'b0;
    for (int unsigned i = 0; i <= d && i < TO; i++) begin
      e = base(); e.memReq = 1'b1; e.iord = 1'b1;
      e.mrd = (op == OP_LOAD); e.mwr = (op == OP_ST);
      if (i == d) begin
        step(1'b0, 1'b1, rb(), op, e, "mem-accept");
        if (op == OP_ST) mInstret++;
        ok = 1'b1;
        return;
      end
      step(1'b0, 1'b0, rb(), op, e, (i == TO - 1) ? "mem-timeout" : "mem-wait");
    end
    mBusErr = 1'b1;
  endtask

  task automatic doWb(input logic [6:0] op);
    exp_t e;
    e = base(); e.regw = 1'b1;
    e.m2r = (op == OP_LOAD) ? 3'd1 : (op == OP_JAL || op == OP_JALR) ? 3'd2 : (op == OP_LUI) ? 3'd3 : 3'd0;
    step(1'b0, rb(), rb(), op, e, "wb");
    mInstret++;
  endtask

  function automatic exp_t execExp(logic [6:0] op, logic tbr);
    exp_t e;
    e = base();
    case (op)
      OP_R:           e.aluop = A_FUNCT;
      OP_I:           begin e.alusrc = 1'b1; e.aluop = A_FUNCT; end
      OP_LOAD, OP_ST: e.alusrc = 1'b1;
      OP_BR:          begin e.aluop = A_SUB; e.pcw = tbr; e.pcsel = 2'd1; end
      OP_JAL:         begin e.pcw = 1'b1; e.pcsel = 2'd1; end
      OP_JALR:        begin e.alusrc = 1'b1; e.pcw = 1'b1; e.pcsel = 2'd2; end
      default:        ;
    endcase
    return e;
  endfunction

  task automatic doInstr(input logic [6:0] op, input logic tbr, input int fd, input int md);
    bit ok;
    doFetch(fd);
    step(1'b0, rb(), rb(), op, base(), "decode");
    step(1'b0, rb(), tbr, op, execExp(op, tbr), "exec");
    case (op)
      OP_BR: mInstret++;
      OP_LOAD, OP_ST: begin
        doMem(op, md, ok);
        if (ok && op == OP_LOAD) doWb(op);
      end
      OP_R, OP_I, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: doWb(op);
      default: begin
`ifndef MULTICYCLE_CTL_TRAP_EN
        mInstret++;
`endif
      end
    endcase
  endtask

  logic [6:0] pool [10] = '{OP_R, OP_I, OP_LOAD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_BAD};

  initial begin
    exp_t e;
    @(posedge clk);
    step(1'b1, 1'b1, 1'b0, 7'h00, base(), "reset");
    #1;
    lit("reset-mem_req", mem_req, 0);
    lit("reset-instret", instret, 0);
    lit("reset-bus_err", bus_err, 0);

    doInstr(OP_R, 1'b0, 0, -1);
    expectNext("add", 1, 0);
    doInstr(OP_LOAD, 1'b0, 0, 3);
    expectNext("lw", 2, 0);
    doInstr(OP_BR, 1'b1, 0, -1);
    doInstr(OP_BR, 1'b0, 0, -1);
    expectNext("beq", 4, 0);
`ifndef MULTICYCLE_CTL_TRAP_EN
    doInstr(OP_BAD, 1'b0, 0, -1);
    expectNext("unknown-nop", 5, 0);
`endif
    doInstr(OP_R, 1'b0, TO + 1, -1);
    expectNext("fetch-timeout-sticky", NB + 1, 1);

    // reset while a load is waiting in MEM
    doFetch(0);
    step(1'b0, 1'b0, 1'b0, OP_LOAD, base(), "decode");
    step(1'b0, 1'b0, 1'b0, OP_LOAD, execExp(OP_LOAD, 1'b0), "exec");
    e = base(); e.memReq = 1'b1; e.iord = 1'b1; e.mrd = 1'b1;
    step(1'b0, 1'b0, 1'b0, OP_LOAD, e, "mem-wait");
    step(1'b0, 1'b0, 1'b0, OP_LOAD, e, "mem-wait");
    step(1'b1, 1'b1, 1'b0, OP_LOAD, base(), "rst-mid-mem");
    mBusErr = 1'b0; mInstret = 0;
    expectNext("after-rst", 0, 0);

    for (int n = 0; n < 150; n++)
      doInstr(pool[$urandom_range(0, NPOOL - 1)], rb(), -1, -1);

`ifdef MULTICYCLE_CTL_TRAP_EN
    doInstr(OP_BAD, 1'b0, 0, -1);
    for (int k = 0; k < 3; k++) step(1'b0, rb(), rb(), 7'($urandom), base(), "trap-hold");
    #1;
    lit("trap-illegal_inst", illegal_inst, 1);
`endif

    @(posedge clk);
    curValid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
